// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO: circular pointer arithmetic.
package stream_fifo_pkg;

    // Advance a circular pointer, wrapping from depth-1 back to 0.
    function automatic logic [31:0] wrap_inc(logic [31:0] ptr, int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Depth x WordWidth register array: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned WordWidth = 64,
    localparam int unsigned AddrW    = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrW-1:0]     waddr_i,
    input  logic [WordWidth-1:0] wdata_i,
    input  logic [AddrW-1:0]     raddr_i,
    output logic [WordWidth-1:0] rdata_o
);

    logic [WordWidth-1:0] mem_q [Depth];

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready stream FIFO with synchronous flush.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned Depth     = 8,
    parameter int unsigned WordWidth = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enq_vld_i,
    input  logic [WordWidth-1:0] enq_payload_i,
    output logic                 enq_rdy_o,
    output logic                 deq_vld_o,
    output logic [WordWidth-1:0] deq_payload_o,
    input  logic                 deq_rdy_i,
    input  logic                 flush_i
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            enq_fire;
    logic            deq_fire;

    // Ready depends on state only, so a full FIFO never accepts on the cycle it is read.
    assign enq_rdy_o = (count_q != CntW'(Depth));
    assign deq_vld_o = (count_q != '0);
    assign enq_fire  = enq_vld_i & enq_rdy_o;
    assign deq_fire  = deq_vld_o & deq_rdy_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = PtrW'(wrap_inc(32'(wr_ptr_q), Depth));
            end
            if (deq_fire) begin
                rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), Depth));
            end
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    stream_fifo_mem #(
        .Depth     (Depth),
        .WordWidth (WordWidth)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (enq_fire & ~flush_i & rstn),
        .waddr_i (wr_ptr_q),
        .wdata_i (enq_payload_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (deq_payload_o)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard-driven bench for stream_fifo: directed scenarios plus a random run.
module tb_stream_fifo;

    localparam int unsigned Depth     = 8;
    localparam int unsigned WordWidth = 64;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 enq_vld_i = 1'b0;
    logic [WordWidth-1:0] enq_payload_i = '0;
    logic                 enq_rdy_o;
    logic                 deq_vld_o;
    logic [WordWidth-1:0] deq_payload_o;
    logic                 deq_rdy_i = 1'b0;
    logic                 flush_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WordWidth-1:0] sb [$];

    always #5 clk = ~clk;

    stream_fifo #(
        .Depth     (Depth),
        .WordWidth (WordWidth)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enq_vld_i     (enq_vld_i),
        .enq_payload_i (enq_payload_i),
        .enq_rdy_o     (enq_rdy_o),
        .deq_vld_o     (deq_vld_o),
        .deq_payload_o (deq_payload_o),
        .deq_rdy_i     (deq_rdy_i),
        .flush_i       (flush_i)
    );

    // One clock of stimulus; the queue model decides what fires. Called #1 after a posedge.
    task automatic drive(input logic ev, input logic [WordWidth-1:0] d, input logic dr,
                         input logic fl, output logic deqd,
                         output logic [WordWidth-1:0] got, output logic [WordWidth-1:0] exp);
        logic m_enq, m_deq;
        m_enq = ev && (sb.size() < Depth);
        m_deq = dr && (sb.size() > 0);
        enq_vld_i     = ev;
        enq_payload_i = d;
        deq_rdy_i     = dr;
        flush_i       = fl;
        got  = deq_payload_o;
        exp  = m_deq ? sb[0] : '0;
        deqd = m_deq && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_deq) void'(sb.pop_front());
            if (m_enq) sb.push_back(d);
        end
        enq_vld_i = 1'b0;
        deq_rdy_i = 1'b0;
        flush_i   = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (deq_vld_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_deq_vld: got %b want 0", deq_vld_o);
        end
        n_tests++;
        if (enq_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_enq_rdy: got %b want 1", enq_rdy_o);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (deq_vld_o !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_deq_vld: got %b want 0", deq_vld_o);
        end
        n_tests++;
        if (enq_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_enq_rdy: got %b want 1", enq_rdy_o);
        end
        sb.delete();
    endtask

    task automatic test_fill_drain();
        logic deqd;
        logic [WordWidth-1:0] got, exp;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, WordWidth'(i), 1'b0, 1'b0, deqd, got, exp);
            n_tests++;
            if (enq_rdy_o !== (i < 8)) begin
                n_fail++; $display("FAIL fill_enq_rdy[%0d]: got %b want %b", i, enq_rdy_o, i < 8);
            end
        end
        n_tests++;
        if (deq_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL fill_deq_vld: got %b want 1", deq_vld_o);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, deqd, got, exp);
            n_tests++;
            if (!deqd || got !== WordWidth'(i) || exp !== WordWidth'(i)) begin
                n_fail++; $display("FAIL drain_word[%0d]: got %h want %h", i, got, WordWidth'(i));
            end
        end
        n_tests++;
        if (deq_vld_o !== 1'b0 || enq_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drained_flags: got vld=%b rdy=%b want vld=0 rdy=1", deq_vld_o, enq_rdy_o);
        end
    endtask

    task automatic test_concurrent();
        logic deqd;
        logic [WordWidth-1:0] got, exp;
        logic [WordWidth-1:0] want [4];
        want[0] = 64'h11; want[1] = 64'h12; want[2] = 64'hAA; want[3] = '0;
        for (int i = 0; i < 3; i++) drive(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0, deqd, got, exp);
        drive(1'b1, 64'hAA, 1'b1, 1'b0, deqd, got, exp);
        n_tests++;
        if (!deqd || got !== 64'h10) begin
            n_fail++; $display("FAIL concurrent_head: got %h want 10", got);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (deq_vld_o !== 1'b1) begin
                n_fail++; $display("FAIL concurrent_vld[%0d]: got %b want 1", i, deq_vld_o);
            end
            drive(1'b0, '0, 1'b1, 1'b0, deqd, got, exp);
            n_tests++;
            if (got !== want[i]) begin
                n_fail++; $display("FAIL concurrent_order[%0d]: got %h want %h", i, got, want[i]);
            end
        end
        n_tests++;
        if (deq_vld_o !== 1'b0) begin
            n_fail++; $display("FAIL concurrent_count: got vld=%b want 0 after 3 words", deq_vld_o);
        end
    endtask

    task automatic test_full_deq();
        logic deqd;
        logic [WordWidth-1:0] got, exp;
        for (int i = 0; i < 8; i++) drive(1'b1, 64'h20 + 64'(i), 1'b0, 1'b0, deqd, got, exp);
        drive(1'b1, 64'h99, 1'b1, 1'b0, deqd, got, exp);
        n_tests++;
        if (got !== 64'h20) begin
            n_fail++; $display("FAIL full_deq_head: got %h want 20", got);
        end
        n_tests++;
        if (enq_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL full_deq_rdy: got %b want 1", enq_rdy_o);
        end
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, deqd, got, exp);
            n_tests++;
            if (got !== 64'h20 + 64'(i)) begin
                n_fail++; $display("FAIL full_deq_word[%0d]: got %h want %h", i, got, 64'h20 + 64'(i));
            end
        end
        n_tests++;
        if (deq_vld_o !== 1'b0) begin
            n_fail++; $display("FAIL full_deq_dropped: got vld=%b want 0 (no 0x99)", deq_vld_o);
        end
    endtask

    task automatic test_flush();
        logic deqd;
        logic [WordWidth-1:0] got, exp;
        for (int i = 0; i < 5; i++) drive(1'b1, 64'h40 + 64'(i), 1'b0, 1'b0, deqd, got, exp);
        drive(1'b1, 64'h55, 1'b0, 1'b1, deqd, got, exp);
        n_tests++;
        if (deq_vld_o !== 1'b0 || enq_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_flags: got vld=%b rdy=%b want vld=0 rdy=1", deq_vld_o, enq_rdy_o);
        end
        drive(1'b1, 64'h66, 1'b0, 1'b0, deqd, got, exp);
        drive(1'b0, '0, 1'b1, 1'b0, deqd, got, exp);
        n_tests++;
        if (!deqd || got !== 64'h66) begin
            n_fail++; $display("FAIL flush_next_word: got %h want 66", got);
        end
    endtask

    task automatic test_random();
        logic deqd, ev, dr;
        logic [WordWidth-1:0] got, exp, d;
        for (int i = 0; i < 20000; i++) begin
            n_tests++;
            if (enq_rdy_o !== (sb.size() < Depth) || deq_vld_o !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL random_flags[%0d]: got rdy=%b vld=%b model size %0d",
                         i, enq_rdy_o, deq_vld_o, sb.size());
            end
            ev = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom};
            drive(ev, d, dr, 1'b0, deqd, got, exp);
            if (deqd) begin
                n_tests++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL random_word[%0d]: got %h want %h", i, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_concurrent();
        test_full_deq();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
